match_score_ctl: RTL and testbench

- Penalty-shootout referee: counts kicks and goals for player and enemy, applies shootout rules, raises end-of-match.
- Sits directly upstream of the game state selector: drives its match_end, match_result and is_shooted inputs, and reads back game_state/game_mode.
- Kick outcomes arrive as one-cycle strobes from the shot-resolution logic.

---
 rtl/match_score_ctl_if.sv | 30 +++
 rtl/match_score_ctl.sv | 217 +++++++++++++++++++++
 tb/tb_match_score_ctl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/match_score_ctl_if.sv
// Referee bus shared with the game state selector and the shot-resolution logic.
// game_state: 0 START, 1 KEEPER, 2 SHOOTER, 3 WINNER, 4 LOSER; game_mode: 0 SOLO, 1 MULTI.
interface match_score_ctl_if #(
    parameter int unsigned ROUNDS = 5,
    parameter int unsigned CNT_W  = 4
);
    logic [2:0]        game_state;
    logic              game_mode;
    logic              round_done;
    logic              goal;
    logic              match_end;
    logic              match_result;
    logic              is_shooted;
    logic [CNT_W-1:0]  player_score;
    logic [CNT_W-1:0]  enemy_score;
    logic [ROUNDS-1:0] player_hist;
    logic [ROUNDS-1:0] enemy_hist;

    modport master (
        output game_state, game_mode, round_done, goal,
        input  match_end, match_result, is_shooted,
        input  player_score, enemy_score, player_hist, enemy_hist
    );

    modport slave (
        input  game_state, game_mode, round_done, goal,
        output match_end, match_result, is_shooted,
        output player_score, enemy_score, player_hist, enemy_hist
    );
endinterface

// File: rtl/match_score_ctl.sv
// Penalty-shootout referee: counts kicks/goals per side, applies shootout rules, flags match end.
// Optional per-kick goal history for regulation kicks is built when SCORE_HISTORY_EN is defined.
module match_score_ctl #(
    parameter int unsigned ROUNDS           = 5,
    parameter int unsigned MAX_KICKS        = 15,
    parameter int unsigned SOLO_MAX_CONCEDE = 2,
    parameter int unsigned CNT_W            = $clog2(MAX_KICKS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    match_score_ctl_if.slave bus
);
    typedef enum logic [2:0] {
        START   = 3'd0,
        KEEPER  = 3'd1,
        SHOOTER = 3'd2,
        WINNER  = 3'd3,
        LOSER   = 3'd4
    } g_state;

    typedef enum logic {
        SOLO  = 1'b0,
        MULTI = 1'b1
    } g_mode;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        DECIDE = 2'd2,
        END    = 2'd3
    } fsm_state;

    localparam logic [CNT_W-1:0] ROUNDS_C  = CNT_W'(ROUNDS);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_KICKS);
    localparam logic [CNT_W-1:0] CONCEDE_C = CNT_W'(SOLO_MAX_CONCEDE);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    g_state           gs;
    g_mode            gm;
    fsm_state         state, state_n;
    logic [CNT_W-1:0] p_shots, p_shots_n;
    logic [CNT_W-1:0] e_shots, e_shots_n;
    logic [CNT_W-1:0] p_goals, p_goals_n;
    logic [CNT_W-1:0] e_goals, e_goals_n;
    logic             match_end_q, match_end_n;
    logic             match_result_q, match_result_n;
    logic             is_shooted_q, is_shooted_n;
    logic             p_kick, e_kick;
    logic             in_reg, end_hit, end_win;
    logic [CNT_W:0]   p_best, e_best;

    assign gs = g_state'(bus.game_state);
    assign gm = g_mode'(bus.game_mode);

    assign p_kick = bus.round_done && (gs == SHOOTER);
    assign e_kick = bus.round_done && (gs == KEEPER);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == MAX_C) ? v : v + ONE_C;
    endfunction

    // Best final score each side can still reach within regulation; only meaningful while in_reg.
    assign in_reg = (p_shots <= ROUNDS_C) && (e_shots <= ROUNDS_C);
    assign p_best = {1'b0, p_goals} + {1'b0, ROUNDS_C} - {1'b0, p_shots};
    assign e_best = {1'b0, e_goals} + {1'b0, ROUNDS_C} - {1'b0, e_shots};

    always_comb begin
        end_hit = 1'b0;
        end_win = 1'b0;
        if (gm == SOLO) begin
            if (e_goals > CONCEDE_C) begin
                end_hit = 1'b1;
            end else if (e_shots == ROUNDS_C) begin
                end_hit = 1'b1;
                end_win = 1'b1;
            end
        end else if (in_reg && (p_best < {1'b0, e_goals})) begin
            end_hit = 1'b1;
        end else if (in_reg && (e_best < {1'b0, p_goals})) begin
            end_hit = 1'b1;
            end_win = 1'b1;
        end else if ((p_shots == e_shots) && (p_shots >= ROUNDS_C) && (p_goals != e_goals)) begin
            end_hit = 1'b1;
            end_win = (p_goals > e_goals);
        end else if ((p_shots == e_shots) && (p_shots == MAX_C)) begin
            end_hit = 1'b1;
        end
    end

    always_comb begin
        state_n        = state;
        p_shots_n      = p_shots;
        e_shots_n      = e_shots;
        p_goals_n      = p_goals;
        e_goals_n      = e_goals;
        match_end_n    = match_end_q;
        match_result_n = match_result_q;
        is_shooted_n   = 1'b0;
        // START overrides everything, including a kick strobe in the same cycle.
        if (gs == START) begin
            state_n        = IDLE;
            p_shots_n      = '0;
            e_shots_n      = '0;
            p_goals_n      = '0;
            e_goals_n      = '0;
            match_end_n    = 1'b0;
            match_result_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ((gs == KEEPER) || (gs == SHOOTER)) begin
                        state_n = PLAY;
                    end
                end
                PLAY: begin
                    if (p_kick) begin
                        p_shots_n = sat_inc(p_shots);
                        if (bus.goal) begin
                            p_goals_n = sat_inc(p_goals);
                        end
                        state_n = DECIDE;
                    end else if (e_kick) begin
                        e_shots_n = sat_inc(e_shots);
                        if (bus.goal) begin
                            e_goals_n = sat_inc(e_goals);
                        end
                        state_n = DECIDE;
                    end
                end
                DECIDE: begin
                    if (end_hit) begin
                        match_end_n    = 1'b1;
                        match_result_n = end_win;
                        state_n        = END;
                    end else begin
                        is_shooted_n = (gm == MULTI);
                        state_n      = PLAY;
                    end
                end
                END: begin
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            p_shots        <= '0;
            e_shots        <= '0;
            p_goals        <= '0;
            e_goals        <= '0;
            match_end_q    <= 1'b0;
            match_result_q <= 1'b0;
            is_shooted_q   <= 1'b0;
        end else begin
            state          <= state_n;
            p_shots        <= p_shots_n;
            e_shots        <= e_shots_n;
            p_goals        <= p_goals_n;
            e_goals        <= e_goals_n;
            match_end_q    <= match_end_n;
            match_result_q <= match_result_n;
            is_shooted_q   <= is_shooted_n;
        end
    end

    assign bus.match_end    = match_end_q;
    assign bus.match_result = match_result_q;
    assign bus.is_shooted   = is_shooted_q;
    assign bus.player_score = p_goals;
    assign bus.enemy_score  = e_goals;

`ifdef SCORE_HISTORY_EN
    logic [ROUNDS-1:0] p_hist, p_hist_n;
    logic [ROUNDS-1:0] e_hist, e_hist_n;

    // Bit k records the kick whose pre-increment shot count is k; sudden death leaves hist alone.
    always_comb begin
        p_hist_n = p_hist;
        e_hist_n = e_hist;
        if (gs == START) begin
            p_hist_n = '0;
            e_hist_n = '0;
        end else if (state == PLAY) begin
            for (int unsigned k = 0; k < ROUNDS; k++) begin
                if (p_kick && (p_shots == CNT_W'(k))) begin
                    p_hist_n[k] = bus.goal;
                end
                if (e_kick && (e_shots == CNT_W'(k))) begin
                    e_hist_n[k] = bus.goal;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_hist <= '0;
            e_hist <= '0;
        end else begin
            p_hist <= p_hist_n;
            e_hist <= e_hist_n;
        end
    end

    assign bus.player_hist = p_hist;
    assign bus.enemy_hist  = e_hist;
`else
    assign bus.player_hist = '0;
    assign bus.enemy_hist  = '0;
`endif

endmodule

// File: tb/tb_match_score_ctl.sv
// Scoreboard bench for match_score_ctl: kicks push expected events, a forked monitor checks them.
`timescale 1ns/1ps
module tb_match_score_ctl;
    localparam int ROUNDS    = 5;
    localparam int MAX_KICKS = 15;
    localparam int SOLO_MAX  = 2;
    localparam int CNT_W     = 4;

    localparam logic [2:0] GS_START   = 3'd0;
    localparam logic [2:0] GS_KEEPER  = 3'd1;
    localparam logic [2:0] GS_SHOOTER = 3'd2;

    typedef struct {
        bit is_end;
        bit win;
        int pscore;
        int escore;
        int at_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t exp_q[$];
    bit   p_log[$];
    bit   e_log[$];
    bit   m_multi;
    bit   m_over;
    bit   m_win;

    match_score_ctl_if #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) bus ();

    match_score_ctl #(
        .ROUNDS(ROUNDS),
        .MAX_KICKS(MAX_KICKS),
        .SOLO_MAX_CONCEDE(SOLO_MAX),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int goals(input bit q[$]);
        int s = 0;
        foreach (q[i]) s += int'(q[i]);
        return s;
    endfunction

    function automatic int hist_of(input bit q[$]);
        int h = 0;
`ifdef SCORE_HISTORY_EN
        for (int i = 0; i < q.size() && i < ROUNDS; i++) h += int'(q[i]) << i;
`endif
        return h;
    endfunction

    // Shootout rules over the kick logs: a side loses in regulation once it cannot catch up.
    function automatic void judge(output bit done, output bit win);
        int ps = p_log.size();
        int es = e_log.size();
        int pg = goals(p_log);
        int eg = goals(e_log);
        done = 1'b0;
        win  = 1'b0;
        if (!m_multi) begin
            if (eg > SOLO_MAX) done = 1'b1;
            else if (es == ROUNDS) begin done = 1'b1; win = 1'b1; end
        end else if (ps <= ROUNDS && es <= ROUNDS && pg + (ROUNDS - ps) < eg) begin
            done = 1'b1;
        end else if (ps <= ROUNDS && es <= ROUNDS && eg + (ROUNDS - es) < pg) begin
            done = 1'b1; win = 1'b1;
        end else if (ps == es && ps >= ROUNDS && pg != eg) begin
            done = 1'b1; win = (pg > eg);
        end else if (ps == es && ps == MAX_KICKS) begin
            done = 1'b1;
        end
    endfunction

    task automatic check_scores(input string tag);
        chk({tag, "_player_score"}, int'(bus.player_score), goals(p_log));
        chk({tag, "_enemy_score"}, int'(bus.enemy_score), goals(e_log));
        chk({tag, "_player_hist"}, int'(bus.player_hist), hist_of(p_log));
        chk({tag, "_enemy_hist"}, int'(bus.enemy_hist), hist_of(e_log));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_match_end"}, int'(bus.match_end), 0);
        chk({tag, "_match_result"}, int'(bus.match_result), 0);
        chk({tag, "_is_shooted"}, int'(bus.is_shooted), 0);
        check_scores(tag);
    endtask

    // Entered and left at posedge+1; twice holds round_done into the DECIDE cycle.
    task automatic kick(input bit player, input bit g, input bit twice);
        bit   done, win;
        exp_t e;
        bus.game_state = player ? GS_SHOOTER : GS_KEEPER;
        bus.round_done = 1'b1;
        bus.goal       = g;
        @(posedge clk); #1;
        if (!m_over) begin
            if (player) p_log.push_back(g);
            else        e_log.push_back(g);
            judge(done, win);
            if (done || m_multi) begin
                e.is_end = done;
                e.win    = win;
                e.pscore = goals(p_log);
                e.escore = goals(e_log);
                e.at_cyc = cyc + 1;
                exp_q.push_back(e);
            end
            m_over = done;
            m_win  = win;
        end
        if (twice) begin
            bus.goal = 1'b1;
            @(posedge clk); #1;
        end
        bus.round_done = 1'b0;
        bus.goal       = 1'b0;
        check_scores("kick");
        repeat (3) @(posedge clk);
        #1;
        chk("match_end_level", int'(bus.match_end), int'(m_over));
        chk("match_result_level", int'(bus.match_result), int'(m_over && m_win));
    endtask

    // START with a simultaneous kick strobe: the kick must be discarded and everything cleared.
    task automatic begin_match(input bit multi);
        bus.game_state = GS_START;
        bus.round_done = 1'b1;
        bus.goal       = 1'b1;
        @(posedge clk); #1;
        bus.round_done = 1'b0;
        bus.goal       = 1'b0;
        p_log.delete();
        e_log.delete();
        m_over  = 1'b0;
        m_win   = 1'b0;
        m_multi = multi;
        check_cleared("start");
        bus.game_mode  = multi;
        bus.game_state = GS_KEEPER;
        @(posedge clk); #1;
    endtask

    task automatic monitor();
        bit   end_prev;
        exp_t e;
        end_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && (bus.is_shooted || (bus.match_end && !end_prev))) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: is_shooted=%0b match_end=%0b with nothing expected (cycle %0d)",
                             bus.is_shooted, bus.match_end, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_cycle", cyc, e.at_cyc);
                    chk("event_match_end", int'(bus.match_end), int'(e.is_end));
                    chk("event_is_shooted", int'(bus.is_shooted), int'(!e.is_end));
                    chk("event_match_result", int'(bus.match_result), int'(e.win));
                    chk("event_player_score", int'(bus.player_score), e.pscore);
                    chk("event_enemy_score", int'(bus.enemy_score), e.escore);
                end
            end
            end_prev = bus.match_end;
        end
    endtask

    initial begin
        bus.game_state = GS_START;
        bus.game_mode  = 1'b0;
        bus.round_done = 1'b0;
        bus.goal       = 1'b0;
        fork
            monitor();
            begin
                #1_000_000;
                $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
                $fatal(1, "watchdog expired");
            end
        join_none

        @(posedge clk); #1;
        check_cleared("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // SOLO: concede 2 of 5 -> win
        begin_match(1'b0);
        kick(0, 1, 0); kick(0, 0, 0); kick(0, 0, 0); kick(0, 1, 0); kick(0, 0, 0);
        chk("solo_win_enemy_score", int'(bus.enemy_score), 2);

        // SOLO: 3 straight goals -> loss; a further kick changes nothing
        begin_match(1'b0);
        kick(0, 1, 0); kick(0, 1, 0); kick(0, 1, 0);
        chk("solo_loss_enemy_score", int'(bus.enemy_score), 3);
        kick(0, 1, 0);

        // MULTI: player 3-0 decided after the 6th kick
        begin_match(1'b1);
        for (int i = 0; i < 3; i++) begin
            kick(1, 1, 0);
            kick(0, 0, 0);
        end
        chk("multi_early_player_score", int'(bus.player_score), 3);

        // MULTI: 3-3 after regulation, then sudden death 1-0
        begin_match(1'b1);
        for (int i = 0; i < 5; i++) begin
            kick(1, (i < 3), 0);
            kick(0, (i < 3), 0);
        end
        kick(1, 1, 0);
        kick(0, 0, 0);
        chk("multi_sd_player_score", int'(bus.player_score), 4);

        // MULTI: strobe held into DECIDE is dropped
        begin_match(1'b1);
        kick(1, 0, 1);
        kick(0, 0, 1);
        kick(1, 1, 0);

        // MULTI: all misses up to the kick cap -> tied end, result 0
        begin_match(1'b1);
        for (int i = 0; i < MAX_KICKS; i++) begin
            kick(1, 0, 0);
            kick(0, 0, 0);
        end
        chk("cap_match_end", int'(bus.match_end), 1);

        // Asynchronous reset mid-match
        begin_match(1'b1);
        kick(1, 1, 0);
        kick(0, 1, 0);
        #2 rst = 1'b0;
        #1;
        p_log.delete();
        e_log.delete();
        m_over = 1'b0;
        check_cleared("async_reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // Randomized matches
        for (int m = 0; m < 40; m++) begin
            bit multi;
            int n;
            multi = 1'($urandom_range(0, 1));
            begin_match(multi);
            n = 0;
            while (!m_over && n < 2 * MAX_KICKS + 2) begin
                if (multi) kick(n[0] == 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
                else       kick(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
                n++;
            end
            if ($urandom_range(0, 1) == 1) kick(1'($urandom_range(0, 1)), 1'b1, 0);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("pending_expectations", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
